clk_div_multi: RTL and testbench
================================

// Module: clk_div_multi
// PURPOSE
//  Parametrised multi-mode clock divider for the FPGA pipeline build: derives the slow CPU/display clock from clk_in.
//  Provides a 50% duty clk_out plus one-cycle tick_rise/tick_fall enables in the clk_in domain.
//  Mode selected at run time from NUM_MODES half-period constants. Mode changes take effect only at half-period boundaries.
//  A run/pause control is included; the optional single-step burst supports board debugging.
// PARAMETERS
//  NUM_MODES  4        number of selectable divide modes (2..16)
//  CNT_W      32       counter width; every HALF_k must be < 2**CNT_W
//  HALF0      1500000  half-period, in clk_in cycles, for mode 0 (slow run)
//  HALF1      100      half-period for mode 1 (fast run)
//  HALF2      10       half-period for mode 2
//  HALF3      1        half-period for mode 3; every HALF_k >= 1
// PORTS
//  clk_in      in   1                    system clock, single clock domain
//  rst         in   1                    asynchronous, active-high reset
//  sel         in   SEL_W=$clog2(NUM_MODES)  requested mode
//  run         in   1                    1 = free-running; 0 = pause (hold state)
//  step        in   1                    async single-step request (only with CLK_DIV_STEP_EN)
//  clk_out     out  1                    divided clock, registered
//  tick_rise   out  1                    1-cycle pulse, asserted in the cycle clk_out becomes 1
//  tick_fall   out  1                    1-cycle pulse, asserted in the cycle clk_out becomes 0
//  active_sel  out  SEL_W                mode currently in force
// BEHAVIOUR
//  - Reset (async, immediate):
//    - clk_out=0, cnt=0, active_sel=0, tick_rise=tick_fall=0, step burst idle.
//  - Advancing (run=1 or step burst active):
//    - cnt+1 per clk_in edge.
//    - When cnt==HALF(active_sel)-1:
//      - cnt<=0 and clk_out<=~clk_out.
//      - tick_rise<=~clk_out, tick_fall<=clk_out.
//      - active_sel<=sel.
//    - Otherwise both ticks 0.
//  - Timing:
//    - Half-period is exactly HALF_k cycles; period is 2*HALF_k.
//    - HALF_k=1 gives clk_in/2.
//  - sel changes mid-half-period:
//    - Ignored until the next toggle boundary. No truncated or stretched half-period.
//    - Multiple sel changes before a boundary: only the value sampled at the boundary counts.
//  - sel >= NUM_MODES (non-power-of-2 NUM_MODES): treated as mode 0.
//  - Pause (run=0, no burst):
//    - cnt, clk_out and active_sel hold; ticks 0.
//    - Resume continues from the held cnt.
//  - run toggled on the boundary cycle: the boundary is evaluated with the registered run value of that cycle.
//  - No output combinational from inputs; all outputs registered.
// CONFIGURATION
//  - CLK_DIV_STEP_EN defined:
//    - step passes a 2-FF synchroniser plus rising-edge detect (2-cycle latency).
//    - An edge while run=0 and idle starts a burst.
//    - The burst advances until exactly one tick_rise and the following tick_fall have occurred, then stops with clk_out=0, cnt=0.
//    - If clk_out=1 when the step arrives, the burst first completes the high half (tick_fall), then one full period.
//    - Step edges during a burst or while run=1 are dropped.
//    - run=1 during a burst: the burst ends, free-running continues seamlessly.
//  - CLK_DIV_STEP_EN undefined: step port and burst logic absent; run alone gates advance.
// STRUCTURE
//  - Package clk_div_pkg holds:
//    - sel_t typedef.
//    - HALF_DEFAULT constant array.
//    - half_lookup() function (out-of-range -> mode 0).
//    - Burst FSM enum {IDLE, WAIT_RISE, WAIT_FALL}.
//  - One sub-module, clk_div_sync_edge: 2-FF synchroniser + rising-edge pulse, reset by rst. Used only under CLK_DIV_STEP_EN.
// TESTING (bench HALF = {4,2,1,6})
//  1. rst release, run=1, sel=0 -> clk_out rises at 4th clk_in edge, falls at 8th; tick_rise at edges 4,12,20.
//  2. sel 0->1 at edge 6 -> toggle at edge 8 unchanged; then toggles at 10,12,14; active_sel=1 from edge 8.
//  3. sel=2 from reset -> after first boundary clk_out toggles every edge; tick_rise/tick_fall alternate each cycle.
//  4. run=0 with cnt=2 in mode 3, hold 10 cycles -> no toggle or ticks; after run=1, toggle 4 edges later.
//  5. rst pulse mid-count while clk_out=1 -> clk_out=0 and active_sel=0 before the next clk_in edge.
//  6. [CLK_DIV_STEP_EN] run=0, one step pulse -> exactly one tick_rise and one tick_fall; end clk_out=0; second step mid-burst ignored.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the clk_div_multi divider family.
package clk_div_pkg;

  localparam int MAX_MODES = 16;

  typedef logic [3:0]  sel_t;
  typedef logic [31:0] half_arr_t [MAX_MODES];

  localparam half_arr_t HALF_DEFAULT = '{
    32'd1500000, 32'd100, 32'd10, 32'd1,
    32'd1, 32'd1, 32'd1, 32'd1,
    32'd1, 32'd1, 32'd1, 32'd1,
    32'd1, 32'd1, 32'd1, 32'd1
  };

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    WAIT_FALL = 2'd2
  } burst_state_t;

  // Out-of-range selections fall back to mode 0.
  function automatic logic [31:0] half_lookup(input half_arr_t tbl, input sel_t s,
                                              input int unsigned num_modes);
    if (32'(s) >= num_modes) return tbl[0];
    return tbl[s];
  endfunction

endpackage

// File: rtl/clk_div_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, followed by a rising-edge pulse.
module clk_div_sync_edge (
  input  logic clk_in,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= din;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign pulse = sync2_reg & ~prev_reg;

endmodule

// File: rtl/clk_div_multi.sv
// Run-time selectable 50% duty clock divider with one-cycle rise/fall tick enables.
// Define CLK_DIV_STEP_EN to add the synchronised single-step burst input.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_MODES = 4,
  parameter int CNT_W     = 32,
  parameter int HALF0     = 1500000,
  parameter int HALF1     = 100,
  parameter int HALF2     = 10,
  parameter int HALF3     = 1,
  localparam int SEL_W    = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [SEL_W-1:0] sel,
  input  logic             run,
`ifdef CLK_DIV_STEP_EN
  input  logic             step,
`endif
  output logic             clk_out,
  output logic             tick_rise,
  output logic             tick_fall,
  output logic [SEL_W-1:0] active_sel
);

  half_arr_t        half_tbl;
  logic [31:0]      half_cur;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] last_cnt;
  logic             boundary;
  logic             advance;
  logic [31:0]      sel_wide;
  logic [SEL_W-1:0] sel_eff;

  generate
    for (genvar gi = 0; gi < MAX_MODES; gi++) begin : g_half
      if (gi == 0) begin : g_m0
        assign half_tbl[gi] = 32'(HALF0);
      end else if (gi == 1) begin : g_m1
        assign half_tbl[gi] = 32'(HALF1);
      end else if (gi == 2) begin : g_m2
        assign half_tbl[gi] = 32'(HALF2);
      end else if (gi == 3) begin : g_m3
        assign half_tbl[gi] = 32'(HALF3);
      end else begin : g_mx
        assign half_tbl[gi] = HALF_DEFAULT[gi];
      end
    end
  endgenerate

  assign half_cur = half_lookup(half_tbl, sel_t'(active_sel), NUM_MODES);
  assign last_cnt = CNT_W'(half_cur - 32'd1);
  assign boundary = (cnt_reg == last_cnt);

  // Unused encodings of a non-power-of-2 mode count map onto mode 0.
  assign sel_wide = 32'(sel);
  assign sel_eff  = (sel_wide < 32'(NUM_MODES)) ? sel : '0;

`ifdef CLK_DIV_STEP_EN
  burst_state_t burst_reg;
  burst_state_t burst_next;
  logic         step_pulse;

  clk_div_sync_edge u_step_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .din    (step),
    .pulse  (step_pulse)
  );

  // A burst runs through one rising boundary and the falling boundary after it.
  always_comb begin
    burst_next = burst_reg;
    if (run) begin
      burst_next = IDLE;
    end else begin
      case (burst_reg)
        IDLE:      if (step_pulse) burst_next = WAIT_RISE;
        WAIT_RISE: if (boundary && !clk_out) burst_next = WAIT_FALL;
        WAIT_FALL: if (boundary && clk_out) burst_next = IDLE;
        default:   burst_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) burst_reg <= IDLE;
    else     burst_reg <= burst_next;
  end

  assign advance = run | (burst_reg != IDLE);
`else
  assign advance = run;
`endif

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      clk_out    <= 1'b0;
      tick_rise  <= 1'b0;
      tick_fall  <= 1'b0;
      active_sel <= '0;
    end else begin
      tick_rise <= 1'b0;
      tick_fall <= 1'b0;
      if (advance) begin
        if (boundary) begin
          cnt_reg    <= '0;
          clk_out    <= ~clk_out;
          tick_rise  <= ~clk_out;
          tick_fall  <= clk_out;
          active_sel <= sel_eff;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi with HALF = {4,2,1,6}.
module tb_clk_div_multi;

  localparam int H [4] = '{4, 2, 1, 6};

  logic       clk_in = 1'b0;
  logic       rst    = 1'b1;
  logic       run    = 1'b0;
  logic [1:0] sel    = 2'd0;
`ifdef CLK_DIV_STEP_EN
  logic       step   = 1'b0;
`endif
  logic       clk_out;
  logic       tick_rise;
  logic       tick_fall;
  logic [1:0] active_sel;

  clk_div_multi #(
    .NUM_MODES (4),
    .CNT_W     (8),
    .HALF0     (4),
    .HALF1     (2),
    .HALF2     (1),
    .HALF3     (6)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .sel        (sel),
    .run        (run),
`ifdef CLK_DIV_STEP_EN
    .step       (step),
`endif
    .clk_out    (clk_out),
    .tick_rise  (tick_rise),
    .tick_fall  (tick_fall),
    .active_sel (active_sel)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic       c;
    logic       r;
    logic       f;
    logic [1:0] s;
  } exp_t;

  exp_t sb_q [$];
  int   rise_q [$];
  int   fall_q [$];
  int   n_vec  = 0;
  int   n_err  = 0;
  int   edge_n = 0;

  int         m_cnt;
  logic       m_clk, m_r, m_f;
  logic [1:0] m_sel;
  int         m_burst;
`ifdef CLK_DIV_STEP_EN
  logic       m_s1, m_s2, m_s3;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_clk = 1'b0; m_r = 1'b0; m_f = 1'b0; m_sel = 2'd0; m_burst = 0;
`ifdef CLK_DIV_STEP_EN
    m_s1 = 1'b0; m_s2 = 1'b0; m_s3 = 1'b0;
`endif
  endtask

  // Reference behaviour for one clk_in edge, using pre-edge state and inputs.
  task automatic model_edge();
    logic adv, bnd;
    int   nb;
    adv = run | (m_burst != 0);
    bnd = (m_cnt == H[m_sel] - 1);
    nb  = m_burst;
`ifdef CLK_DIV_STEP_EN
    if (run)                                nb = 0;
    else if (m_burst == 0 && m_s2 && !m_s3) nb = 1;
    else if (m_burst == 1 && bnd && !m_clk) nb = 2;
    else if (m_burst == 2 && bnd && m_clk)  nb = 0;
    m_s3 = m_s2; m_s2 = m_s1; m_s1 = step;
`endif
    m_r = 1'b0; m_f = 1'b0;
    if (adv) begin
      if (bnd) begin
        m_cnt = 0; m_r = ~m_clk; m_f = m_clk; m_clk = ~m_clk; m_sel = sel;
      end else begin
        m_cnt++;
      end
    end
    m_burst = nb;
  endtask

  task automatic cyc();
    exp_t e;
    @(posedge clk_in);
    edge_n++;
    model_edge();
    sb_q.push_back('{m_clk, m_r, m_f, m_sel});
    #1;
    e = sb_q.pop_front();
    check("clk_out", clk_out, e.c);
    check("tick_rise", tick_rise, e.r);
    check("tick_fall", tick_fall, e.f);
    check("active_sel", active_sel, e.s);
    if (tick_rise) rise_q.push_back(edge_n);
    if (tick_fall) fall_q.push_back(edge_n);
    $display("edge %0d run=%0b sel=%0d clk_out=%0b rise=%0b fall=%0b active_sel=%0d",
             edge_n, run, sel, clk_out, tick_rise, tick_fall, active_sel);
  endtask

  task automatic do_reset(input logic [1:0] s, input logic r);
    @(negedge clk_in);
    rst = 1'b1; sel = s; run = r;
    #1;
    check("rst_clk_out", clk_out, 0);
    check("rst_tick_rise", tick_rise, 0);
    check("rst_tick_fall", tick_fall, 0);
    check("rst_active_sel", active_sel, 0);
    model_reset();
    sb_q.delete(); rise_q.delete(); fall_q.delete();
    @(negedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    int base;

    // Mode 0 free run: rises at 4, 12, 20 and first fall at 8.
    do_reset(2'd0, 1'b1);
    repeat (21) cyc();
    check("t1_rise0", rise_q[0], 4);
    check("t1_fall0", fall_q[0], 8);
    check("t1_rise1", rise_q[1], 12);
    check("t1_rise2", rise_q[2], 20);

    // sel changed mid half-period takes effect only at the boundary at edge 8.
    do_reset(2'd0, 1'b1);
    repeat (6) cyc();
    sel = 2'd1;
    repeat (9) cyc();
    check("t2_fall0", fall_q[0], 8);
    check("t2_rise1", rise_q[1], 10);
    check("t2_fall1", fall_q[1], 12);
    check("t2_rise2", rise_q[2], 14);

    // HALF=1 after the first boundary: toggles every edge.
    do_reset(2'd2, 1'b1);
    repeat (10) cyc();
    check("t3_rise1", rise_q[1], 6);
    check("t3_fall1", fall_q[1], 7);
    check("t3_nrise", rise_q.size(), 4);
    check("t3_nfall", fall_q.size(), 3);

    // Pause with cnt=2 in mode 3, then resume: fall 4 edges later.
    do_reset(2'd3, 1'b1);
    repeat (6) cyc();
    run = 1'b0;
    rise_q.delete(); fall_q.delete();
    repeat (10) cyc();
    check("t4_pause_ticks", rise_q.size() + fall_q.size(), 0);
    check("t4_pause_clk", clk_out, 1);
    check("t4_pause_sel", active_sel, 3);
    run = 1'b1;
    base = edge_n;
    repeat (5) cyc();
    check("t4_resume_fall", fall_q[0] - base, 4);

    // Async reset while clk_out=1 and active_sel=1 (checked inside do_reset).
    do_reset(2'd1, 1'b1);
    repeat (5) cyc();
    check("t5_pre_clk", clk_out, 1);
    check("t5_pre_sel", active_sel, 1);
    do_reset(2'd0, 1'b1);

`ifdef CLK_DIV_STEP_EN
    // Single-step burst while paused; a second step mid-burst is dropped.
    do_reset(2'd0, 1'b0);
    repeat (3) cyc();
    rise_q.delete(); fall_q.delete();
    step = 1'b1;
    repeat (2) cyc();
    step = 1'b0;
    repeat (4) cyc();
    step = 1'b1;
    repeat (2) cyc();
    step = 1'b0;
    repeat (20) cyc();
    check("t6_nrise", rise_q.size(), 1);
    check("t6_nfall", fall_q.size(), 1);
    check("t6_rise_edge", rise_q[0], 10);
    check("t6_fall_edge", fall_q[0], 14);
    check("t6_end_clk", clk_out, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
    $fatal(1);
  end

endmodule
